// File: rtl/debug_event_tx_pkg.sv
// debug_pkg: ASCII constants, hex digit helper and FSM states
// for the debug event reporter.
package debug_pkg;

    localparam logic [7:0] ASC_E  = 8'h45;
    localparam logic [7:0] ASC_SP = 8'h20;
    localparam logic [7:0] ASC_0  = 8'h30;
    localparam logic [7:0] ASC_1  = 8'h31;
    localparam logic [7:0] ASC_LF = 8'h0A;
    localparam logic [7:0] ASC_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_GAP,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10)
            return 8'h30 + {4'h0, nib};
        else
            return 8'h37 + {4'h0, nib};
    endfunction

endpackage

// File: rtl/debug_event_tx_if.sv
// Byte link to uart_tx: tx_valid/tx_byte out of the reporter,
// tx_busy back from the transmitter.
interface debug_event_tx_if;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_busy;

    modport master (
        output tx_valid,
        output tx_byte,
        input  tx_busy
    );

    modport slave (
        input  tx_valid,
        input  tx_byte,
        output tx_busy
    );
endinterface

// File: rtl/debug_edge_capture.sv
// Per-channel edge detector with pending flags and level latch.
// Ports: level in, clr (one-hot pend clear), ovf_clr; pend, lvl, overflow out.
module debug_edge_capture #(
    parameter int NUM_EVENTS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] level,
    input  logic [NUM_EVENTS-1:0] clr,
    input  logic                  ovf_clr,
    output logic [NUM_EVENTS-1:0] pend,
    output logic [NUM_EVENTS-1:0] lvl,
    output logic                  overflow
);

    logic [NUM_EVENTS-1:0] prev;
    logic [NUM_EVENTS-1:0] edg;
    logic [NUM_EVENTS-1:0] lost;

    assign edg  = level ^ prev;
    // An edge on a channel being consumed this cycle is not a loss.
    assign lost = edg & pend & ~clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= '0;
            pend     <= '0;
            lvl      <= '0;
            overflow <= 1'b0;
        end else begin
            prev <= level;
            // New capture beats the clear from LOAD.
            pend <= (pend & ~clr) | edg;
            lvl  <= (lvl & ~edg) | (level & edg);
            if (|lost)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/debug_event_tx.sv
// Debug event reporter: emits "E<ch> <0|1> <data hex>\n\r" per edge.
// Ports: clk, rst_n, event_level, event_data, ovf_clr, tx (master), overflow, active.
module debug_event_tx
    import debug_pkg::*;
#(
    parameter int NUM_EVENTS = 4,
    parameter int DATA_W     = 16,
    parameter int GAP_CYCLES = 3840
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_EVENTS-1:0] event_level,
    input  logic [DATA_W-1:0]     event_data,
    input  logic                  ovf_clr,
    debug_event_tx_if.master      tx,
    output logic                  overflow,
    output logic                  active
);

    localparam int HEX_N   = DATA_W / 4;
    localparam int MSG_LEN = 7 + HEX_N;
    localparam int IDX_W   = $clog2(MSG_LEN);
    localparam int CNT_W   = $clog2(GAP_CYCLES + 1);
    localparam int CH_W    = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1;

    logic [NUM_EVENTS-1:0] pend;
    logic [NUM_EVENTS-1:0] lvl;
    logic [NUM_EVENTS-1:0] clr;
    logic [CH_W-1:0]       sel;

    state_t            state;
    logic [CH_W-1:0]   ch_q;
    logic              lvl_q;
    logic [DATA_W-1:0] data_q;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  gap_cnt;
    logic [7:0]        byte_nx;

    debug_edge_capture #(
        .NUM_EVENTS(NUM_EVENTS)
    ) u_cap (
        .clk      (clk),
        .rst_n    (rst_n),
        .level    (event_level),
        .clr      (clr),
        .ovf_clr  (ovf_clr),
        .pend     (pend),
        .lvl      (lvl),
        .overflow (overflow)
    );

    // Descending scan so the lowest pending index is the final winner.
    always_comb begin
        sel = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--)
            if (pend[i])
                sel = CH_W'(i);
    end

    always_comb begin
        clr = '0;
        for (int i = 0; i < NUM_EVENTS; i++)
            clr[i] = (state == ST_LOAD) && (sel == CH_W'(i));
    end

    always_comb begin
        byte_nx = ASC_CR;
        if (idx == IDX_W'(0))
            byte_nx = ASC_E;
        else if (idx == IDX_W'(1))
            byte_nx = hex_ascii(4'(ch_q));
        else if (idx == IDX_W'(2) || idx == IDX_W'(4))
            byte_nx = ASC_SP;
        else if (idx == IDX_W'(3))
            byte_nx = lvl_q ? ASC_1 : ASC_0;
        else if (idx == IDX_W'(MSG_LEN - 2))
            byte_nx = ASC_LF;
        else begin
            for (int j = 0; j < HEX_N; j++)
                if (idx == IDX_W'(5 + j))
                    byte_nx = hex_ascii(data_q[(HEX_N-1-j)*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ch_q        <= '0;
            lvl_q       <= 1'b0;
            data_q      <= '0;
            idx         <= '0;
            gap_cnt     <= '0;
            tx.tx_valid <= 1'b0;
            tx.tx_byte  <= 8'h00;
            active      <= 1'b0;
        end else begin
            tx.tx_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (|pend) begin
                        state  <= ST_LOAD;
                        active <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    ch_q    <= sel;
                    lvl_q   <= lvl[sel];
                    data_q  <= event_data;
                    idx     <= '0;
                    gap_cnt <= '0;
                    state   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_cnt == CNT_W'(GAP_CYCLES - 1))
                        state <= ST_SEND;
                    else
                        gap_cnt <= gap_cnt + 1'b1;
                end
                ST_SEND: begin
                    tx.tx_valid <= 1'b1;
                    tx.tx_byte  <= byte_nx;
                    state       <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (tx.tx_busy)
                        state <= ST_WAIT_LO;
                end
                ST_WAIT_LO: begin
                    if (!tx.tx_busy) begin
                        if (idx == IDX_W'(MSG_LEN - 1)) begin
                            state  <= ST_IDLE;
                            active <= 1'b0;
                        end else begin
                            idx     <= idx + 1'b1;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_event_tx.sv
// Directed bench for debug_event_tx: two DUT configurations,
// a uart_tx busy model per DUT, byte capture and line checks.
module tb_debug_event_tx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;

    logic [3:0]  lvl_a = '0;
    logic [15:0] data_a = '0;
    logic        ovf_clr_a = 1'b0;
    logic        ovf_a, act_a;

    logic [15:0] lvl_b = '0;
    logic [7:0]  data_b = 8'hC4;
    logic        ovf_b, act_b;

    debug_event_tx_if ifa();
    debug_event_tx_if ifb();

    debug_event_tx #(
        .NUM_EVENTS(4), .DATA_W(16), .GAP_CYCLES(8)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .event_level (lvl_a),
        .event_data  (data_a),
        .ovf_clr     (ovf_clr_a),
        .tx          (ifa),
        .overflow    (ovf_a),
        .active      (act_a)
    );

    debug_event_tx #(
        .NUM_EVENTS(16), .DATA_W(8), .GAP_CYCLES(8)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .event_level (lvl_b),
        .event_data  (data_b),
        .ovf_clr     (1'b0),
        .tx          (ifb),
        .overflow    (ovf_b),
        .active      (act_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] rxa[$];
    logic [7:0] rxb[$];
    int first_a = -1;
    int bca = 0, bcb = 0;
    int viol = 0;

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // uart_tx model A: busy seen by the DUT one edge after the strobe.
    initial begin
        ifa.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ifa.tx_valid && ifa.tx_busy) viol++;
            if (bca > 0) begin
                bca--;
                if (bca == 0) ifa.tx_busy = 1'b0;
            end
            if (ifa.tx_valid) begin
                rxa.push_back(ifa.tx_byte);
                if (first_a < 0) first_a = cyc;
                ifa.tx_busy = 1'b1;
                bca = 10;
            end
        end
    end

    initial begin
        ifb.tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (ifb.tx_valid && ifb.tx_busy) viol++;
            if (bcb > 0) begin
                bcb--;
                if (bcb == 0) ifb.tx_busy = 1'b0;
            end
            if (ifb.tx_valid) begin
                rxb.push_back(ifb.tx_byte);
                ifb.tx_busy = 1'b1;
                bcb = 10;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [7:0] q[$],
                              input string exp);
        check({tag, "_len"}, q.size(), exp.len());
        for (int i = 0; i < exp.len(); i++)
            if (i < q.size())
                check($sformatf("%s_b%0d", tag, i), q[i], exp[i]);
    endtask

    task automatic wait_a(input int n, input string tag);
        int k = 0;
        while (rxa.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rxa.size() < n) check({tag, "_timeout"}, rxa.size(), n);
        k = 0;
        while (act_a && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (act_a) check({tag, "_idle_timeout"}, act_a, 0);
        repeat (5) @(negedge clk);
    endtask

    task automatic wait_b(input int n, input string tag);
        int k = 0;
        while (rxb.size() < n && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (rxb.size() < n) check({tag, "_timeout"}, rxb.size(), n);
        k = 0;
        while (act_b && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (act_b) check({tag, "_idle_timeout"}, act_b, 0);
        repeat (5) @(negedge clk);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge clk);
        check("rst_valid", ifa.tx_valid, 0);
        check("rst_byte", ifa.tx_byte, 8'h00);
        check("rst_ovf", ovf_a, 0);
        check("rst_active", act_a, 0);
        rst_n = 1'b1;

        // 1: single rising edge, latency and content
        data_a = 16'h1A3F;
        while (cyc < 9) @(negedge clk);
        lvl_a[2] = 1'b1;
        repeat (5) @(negedge clk);
        check("t1_active", act_a, 1);
        wait_a(11, "t1");
        check("t1_first_cyc", first_a, 21);
        check_line("t1", rxa, "E2 1 1A3F\n\r");
        rxa.delete();

        // 2: simultaneous edges, lowest channel first
        lvl_a[3] = 1'b1;
        lvl_a[0] = 1'b1;
        wait_a(22, "t2");
        check_line("t2", rxa, "E0 1 1A3F\n\rE3 1 1A3F\n\r");
        check("t2_ovf", ovf_a, 0);
        rxa.delete();

        // 3: ch1 toggles while ch0 line is in flight
        lvl_a[0] = 1'b0;
        repeat (5) @(negedge clk);
        lvl_a[1] = 1'b1;
        repeat (2) @(negedge clk);
        lvl_a[1] = 1'b0;
        repeat (2) @(negedge clk);
        lvl_a[1] = 1'b1;
        wait_a(22, "t3");
        check_line("t3", rxa, "E0 0 1A3F\n\rE1 1 1A3F\n\r");
        check("t3_ovf_set", ovf_a, 1);
        ovf_clr_a = 1'b1;
        @(negedge clk);
        ovf_clr_a = 1'b0;
        @(negedge clk);
        check("t3_ovf_clr", ovf_a, 0);
        rxa.delete();

        // 4: data changes mid-line, snapshot holds
        data_a = 16'h0000;
        lvl_a[2] = 1'b0;
        k = 0;
        while (rxa.size() < 6 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        data_a = 16'hFFFF;
        wait_a(11, "t4");
        check_line("t4", rxa, "E2 0 0000\n\r");
        rxa.delete();

        // 5: reset during byte 4
        lvl_a[3] = 1'b0;
        k = 0;
        while (rxa.size() < 4 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("t5_pre_bytes", rxa.size(), 4);
        rst_n = 1'b0;
        #1;
        check("t5_valid", ifa.tx_valid, 0);
        check("t5_active", act_a, 0);
        check("t5_byte", ifa.tx_byte, 8'h00);
        lvl_a = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        check("t5_no_more", rxa.size(), 4);
        check("t5_idle", act_a, 0);
        check("t5_ovf", ovf_a, 0);

        // 6: 16 channels, 8-bit data
        lvl_b[15] = 1'b1;
        wait_b(9, "t6r");
        check_line("t6r", rxb, "EF 1 C4\n\r");
        rxb.delete();
        lvl_b[15] = 1'b0;
        wait_b(9, "t6f");
        check_line("t6f", rxb, "EF 0 C4\n\r");

        check("no_strobe_busy", viol, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
